// File: rtl/trg_clk_phs_shift_ctrl.sv
// Trigger-clock phase-change initiator: handshakes with the start FSM,
// then walks the MMCM dynamic phase shifter one step at a time.
module trg_clk_phs_shift_ctrl #(
  parameter int unsigned PHS_W    = 8,
  parameter int unsigned ACK_TMO  = 255,
  parameter int unsigned PS_TMO   = 1023,
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PHS_REQ,
  input  logic [PHS_W-1:0] PHS_TARGET,
  input  logic             TRG_RST,
  input  logic             MMCM_LOCK,
  input  logic             PSDONE,
  output logic             CLK_PHS_CHNG,
  output logic             PSEN,
  output logic             PSINCDEC,
  output logic [PHS_W-1:0] PHS_CUR,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int unsigned MAX_AP =
    (ACK_TMO > PS_TMO) ? ACK_TMO : PS_TMO;
  localparam int unsigned CNT_MAX =
    (MAX_AP > HOLD_CYC) ? MAX_AP : HOLD_CYC;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TMO - 1);
  localparam logic [CNT_W-1:0] PS_LAST   = CNT_W'(PS_TMO - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_STEP,
    S_WAIT_PS,
    S_WAIT_LOCK,
    S_HOLD,
    S_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PHS_W-1:0] tgt_q, tgt_d;
  logic [PHS_W-1:0] cur_q, cur_d;
  logic             chng_q, chng_d;
  logic             psen_q, psen_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    chng_d  = chng_q;
    psen_d  = 1'b0;
    dir_d   = dir_q;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        chng_d = 1'b0;
        if (PHS_REQ) begin
          tgt_d = PHS_TARGET;
          err_d = 1'b0;
          if (PHS_TARGET == cur_q) begin
            done_d = 1'b1;
          end else begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        chng_d = 1'b1;
        if (TRG_RST) begin
          state_d = S_STEP;
        end else if (cnt_q == ACK_LAST) begin
          state_d = S_ABORT;
        end
      end

      S_STEP: begin
        chng_d  = 1'b1;
        psen_d  = 1'b1;
        dir_d   = (tgt_q > cur_q);
        state_d = S_WAIT_PS;
      end

      S_WAIT_PS: begin
        chng_d = 1'b1;
        if (PSDONE) begin
          cur_d = dir_q ? cur_q + PHS_W'(1)
                        : cur_q - PHS_W'(1);
          state_d = (cur_d != tgt_q) ? S_STEP
                                     : S_WAIT_LOCK;
        end else if (cnt_q == PS_LAST) begin
          state_d = S_ABORT;
        end
      end

      S_WAIT_LOCK: begin
        chng_d = 1'b1;
        if (MMCM_LOCK) begin
          state_d = S_HOLD;
        end else if (cnt_q == PS_LAST) begin
          state_d = S_ABORT;
        end
      end

      // Flag, DONE and BUSY all change on the same edge at hold exit
      S_HOLD: begin
        chng_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          chng_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_ABORT: begin
        chng_d  = 1'b0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      cur_q   <= '0;
      chng_q  <= 1'b0;
      psen_q  <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      chng_q  <= chng_d;
      psen_q  <= psen_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign CLK_PHS_CHNG = chng_q;
  assign PSEN         = psen_q;
  assign PSINCDEC     = dir_q;
  assign PHS_CUR      = cur_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_trg_clk_phs_shift_ctrl.sv
// Directed bench for trg_clk_phs_shift_ctrl with a behavioural
// start-FSM acknowledger and MMCM phase-shift responder.
module tb_trg_clk_phs_shift_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PHS_REQ = 1'b0;
  logic [7:0] PHS_TARGET = 8'd0;
  logic       TRG_RST;
  logic       MMCM_LOCK = 1'b1;
  logic       PSDONE;
  logic       CLK_PHS_CHNG;
  logic       PSEN;
  logic       PSINCDEC;
  logic [7:0] PHS_CUR;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  logic trg_auto = 1'b1;
  logic trg_r = 1'b0;
  logic h0 = 1'b0;
  logic h1 = 1'b0;
  logic resp_ps = 1'b0;
  logic spur_ps = 1'b0;
  logic exp_dir = 1'b1;

  int psen_cnt = 0;
  int dir_err = 0;
  int done_cnt = 0;
  int step_idx = 0;
  int drop_idx = -1;
  int cmp = 0;
  int mism = 0;

  assign TRG_RST = trg_r;
  assign PSDONE  = resp_ps | spur_ps;

  trg_clk_phs_shift_ctrl #(
    .PHS_W(8),
    .ACK_TMO(255),
    .PS_TMO(1023),
    .HOLD_CYC(16)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .PHS_REQ(PHS_REQ),
    .PHS_TARGET(PHS_TARGET),
    .TRG_RST(TRG_RST),
    .MMCM_LOCK(MMCM_LOCK),
    .PSDONE(PSDONE),
    .CLK_PHS_CHNG(CLK_PHS_CHNG),
    .PSEN(PSEN),
    .PSINCDEC(PSINCDEC),
    .PHS_CUR(PHS_CUR),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (PSEN === 1'b1) begin
      psen_cnt <= psen_cnt + 1;
      if (PSINCDEC !== exp_dir) dir_err <= dir_err + 1;
    end
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Start FSM: acknowledges two cycles after the flag rises
  initial forever begin
    @(negedge CLK);
    trg_r = trg_auto & h1;
    h1 = h0;
    h0 = CLK_PHS_CHNG;
  end

  // MMCM: PSDONE 12 cycles after each PSEN unless that step is dropped
  initial forever begin
    @(negedge CLK);
    if (PSEN === 1'b1) begin
      step_idx = step_idx + 1;
      if (step_idx != drop_idx) begin
        repeat (12) @(negedge CLK);
        resp_ps = 1'b1;
        @(negedge CLK);
        resp_ps = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [7:0] t);
    PHS_REQ = 1'b1;
    PHS_TARGET = t;
    @(negedge CLK);
    PHS_REQ = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #3;
    cmp++;
    if ({CLK_PHS_CHNG, PSEN, PSINCDEC, BUSY, DONE, ERR} !== 6'b0 ||
        PHS_CUR !== 8'd0) begin
      mism++;
      $display("FAIL reset_outs: got chng=%b psen=%b dir=%b busy=%b done=%b err=%b cur=%0d, expected all 0",
               CLK_PHS_CHNG, PSEN, PSINCDEC, BUSY, DONE, ERR, PHS_CUR);
    end
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    cmp++;
    if (BUSY !== 1'b0 || CLK_PHS_CHNG !== 1'b0) begin
      mism++;
      $display("FAIL reset_idle: got busy=%b chng=%b, expected 0 0", BUSY, CLK_PHS_CHNG);
    end
  endtask

  task automatic test_basic_up();
    int p0, d0;
    p0 = psen_cnt;
    d0 = done_cnt;
    exp_dir = 1'b1;
    do_req(8'd5);
    @(negedge CLK);
    cmp++;
    if (CLK_PHS_CHNG !== 1'b1 || BUSY !== 1'b1) begin
      mism++;
      $display("FAIL up_start: got chng=%b busy=%b, expected 1 1", CLK_PHS_CHNG, BUSY);
    end
    for (int i = 0; i < 600 && DONE !== 1'b1; i++) @(negedge CLK);
    cmp++;
    if (DONE !== 1'b1) begin
      mism++;
      $display("FAIL up_done_wait: got done=%b, expected 1", DONE);
    end
    cmp++;
    if (PHS_CUR !== 8'd5) begin
      mism++;
      $display("FAIL up_cur: got %0d, expected 5", PHS_CUR);
    end
    cmp++;
    if (CLK_PHS_CHNG !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0) begin
      mism++;
      $display("FAIL up_end: got chng=%b busy=%b err=%b, expected 0 0 0", CLK_PHS_CHNG, BUSY, ERR);
    end
    @(negedge CLK);
    cmp++;
    if (psen_cnt - p0 !== 5) begin
      mism++;
      $display("FAIL up_psen_cnt: got %0d, expected 5", psen_cnt - p0);
    end
    cmp++;
    if (done_cnt - d0 !== 1) begin
      mism++;
      $display("FAIL up_done_cnt: got %0d, expected 1", done_cnt - d0);
    end
    cmp++;
    if (dir_err !== 0) begin
      mism++;
      $display("FAIL up_dir: got %0d wrong-direction steps, expected 0", dir_err);
    end
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_down_and_same();
    int p0, d0;
    p0 = psen_cnt;
    exp_dir = 1'b0;
    do_req(8'd2);
    for (int i = 0; i < 600 && DONE !== 1'b1; i++) @(negedge CLK);
    cmp++;
    if (DONE !== 1'b1 || PHS_CUR !== 8'd2) begin
      mism++;
      $display("FAIL down_cur: got done=%b cur=%0d, expected 1 2", DONE, PHS_CUR);
    end
    @(negedge CLK);
    cmp++;
    if (psen_cnt - p0 !== 3 || dir_err !== 0) begin
      mism++;
      $display("FAIL down_psen: got %0d pulses, %0d wrong dir, expected 3 0", psen_cnt - p0, dir_err);
    end
    repeat (5) @(negedge CLK);
    p0 = psen_cnt;
    d0 = done_cnt;
    do_req(8'd2);
    cmp++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || CLK_PHS_CHNG !== 1'b0) begin
      mism++;
      $display("FAIL same_done: got done=%b busy=%b chng=%b, expected 1 0 0", DONE, BUSY, CLK_PHS_CHNG);
    end
    @(negedge CLK);
    cmp++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || CLK_PHS_CHNG !== 1'b0) begin
      mism++;
      $display("FAIL same_after: got done=%b busy=%b chng=%b, expected 0 0 0", DONE, BUSY, CLK_PHS_CHNG);
    end
    repeat (5) @(negedge CLK);
    cmp++;
    if (psen_cnt != p0 || done_cnt - d0 !== 1 || PHS_CUR !== 8'd2) begin
      mism++;
      $display("FAIL same_quiet: got psen+%0d done+%0d cur=%0d, expected 0 1 2", psen_cnt - p0, done_cnt - d0, PHS_CUR);
    end
  endtask

  task automatic test_ack_timeout();
    int p0;
    p0 = psen_cnt;
    trg_auto = 1'b0;
    do_req(8'd9);
    repeat (255) @(negedge CLK);
    cmp++;
    if (ERR !== 1'b0 || CLK_PHS_CHNG !== 1'b1) begin
      mism++;
      $display("FAIL ack_pre_tmo: got err=%b chng=%b, expected 0 1", ERR, CLK_PHS_CHNG);
    end
    @(negedge CLK);
    cmp++;
    if (ERR !== 1'b1 || CLK_PHS_CHNG !== 1'b0 || BUSY !== 1'b1) begin
      mism++;
      $display("FAIL ack_tmo: got err=%b chng=%b busy=%b, expected 1 0 1", ERR, CLK_PHS_CHNG, BUSY);
    end
    @(negedge CLK);
    cmp++;
    if (BUSY !== 1'b0 || ERR !== 1'b1) begin
      mism++;
      $display("FAIL ack_idle: got busy=%b err=%b, expected 0 1", BUSY, ERR);
    end
    cmp++;
    if (psen_cnt != p0 || PHS_CUR !== 8'd2) begin
      mism++;
      $display("FAIL ack_nostep: got psen+%0d cur=%0d, expected 0 2", psen_cnt - p0, PHS_CUR);
    end
    trg_auto = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_ps_timeout();
    int p0, d0;
    p0 = psen_cnt;
    d0 = done_cnt;
    exp_dir = 1'b1;
    drop_idx = step_idx + 3;
    do_req(8'd10);
    cmp++;
    if (ERR !== 1'b0) begin
      mism++;
      $display("FAIL ps_err_clear: got err=%b, expected 0", ERR);
    end
    for (int i = 0; i < 300 && psen_cnt - p0 < 3; i++) @(negedge CLK);
    repeat (20) @(negedge CLK);
    do_req(8'd0);
    cmp++;
    if (BUSY !== 1'b1 || ERR !== 1'b0 || PHS_CUR !== 8'd4) begin
      mism++;
      $display("FAIL ps_stall: got busy=%b err=%b cur=%0d, expected 1 0 4", BUSY, ERR, PHS_CUR);
    end
    for (int i = 0; i < 1200 && ERR !== 1'b1; i++) @(negedge CLK);
    cmp++;
    if (ERR !== 1'b1 || CLK_PHS_CHNG !== 1'b0) begin
      mism++;
      $display("FAIL ps_tmo: got err=%b chng=%b, expected 1 0", ERR, CLK_PHS_CHNG);
    end
    repeat (20) @(negedge CLK);
    cmp++;
    if (BUSY !== 1'b0 || PHS_CUR !== 8'd4 || psen_cnt - p0 !== 3 || done_cnt != d0) begin
      mism++;
      $display("FAIL ps_after: got busy=%b cur=%0d psen+%0d done+%0d, expected 0 4 3 0",
               BUSY, PHS_CUR, psen_cnt - p0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_step();
    int p0, d0;
    exp_dir = 1'b1;
    do_req(8'd200);
    for (int i = 0; i < 300 && !(PSEN === 1'b1 && PHS_CUR === 8'd1); i++)
      @(negedge CLK);
    d0 = done_cnt;
    #1;
    RST_N = 1'b0;
    #1;
    cmp++;
    if (CLK_PHS_CHNG !== 1'b0 || PSEN !== 1'b0 || PHS_CUR !== 8'd0 ||
        BUSY !== 1'b0 || DONE !== 1'b0) begin
      mism++;
      $display("FAIL rst_async: got chng=%b psen=%b cur=%0d busy=%b done=%b, expected 0 0 0 0 0",
               CLK_PHS_CHNG, PSEN, PHS_CUR, BUSY, DONE);
    end
    repeat (20) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    cmp++;
    if (done_cnt != d0) begin
      mism++;
      $display("FAIL rst_nodone: got %0d done pulses, expected 0", done_cnt - d0);
    end
    p0 = psen_cnt;
    d0 = done_cnt;
    do_req(8'd1);
    for (int i = 0; i < 300 && DONE !== 1'b1; i++) @(negedge CLK);
    @(negedge CLK);
    cmp++;
    if (PHS_CUR !== 8'd1 || ERR !== 1'b0 || psen_cnt - p0 !== 1 || done_cnt - d0 !== 1) begin
      mism++;
      $display("FAIL rst_recover: got cur=%0d err=%b psen+%0d done+%0d, expected 1 0 1 1",
               PHS_CUR, ERR, psen_cnt - p0, done_cnt - d0);
    end
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_lock_wait();
    int p0, d0;
    p0 = psen_cnt;
    d0 = done_cnt;
    exp_dir = 1'b1;
    MMCM_LOCK = 1'b0;
    do_req(8'd3);
    for (int i = 0; i < 300 && PHS_CUR !== 8'd3; i++) @(negedge CLK);
    repeat (50) @(negedge CLK);
    cmp++;
    if (CLK_PHS_CHNG !== 1'b1 || BUSY !== 1'b1 || done_cnt != d0 ||
        psen_cnt - p0 !== 2 || PHS_CUR !== 8'd3) begin
      mism++;
      $display("FAIL lock_wait: got chng=%b busy=%b done+%0d psen+%0d cur=%0d, expected 1 1 0 2 3",
               CLK_PHS_CHNG, BUSY, done_cnt - d0, psen_cnt - p0, PHS_CUR);
    end
    MMCM_LOCK = 1'b1;
    repeat (17) @(negedge CLK);
    cmp++;
    if (CLK_PHS_CHNG !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b1) begin
      mism++;
      $display("FAIL lock_hold: got chng=%b done=%b busy=%b, expected 1 0 1", CLK_PHS_CHNG, DONE, BUSY);
    end
    @(negedge CLK);
    cmp++;
    if (CLK_PHS_CHNG !== 1'b0 || DONE !== 1'b1 || BUSY !== 1'b0) begin
      mism++;
      $display("FAIL lock_release: got chng=%b done=%b busy=%b, expected 0 1 0", CLK_PHS_CHNG, DONE, BUSY);
    end
    repeat (3) @(negedge CLK);
    spur_ps = 1'b1;
    @(negedge CLK);
    spur_ps = 1'b0;
    repeat (2) @(negedge CLK);
    spur_ps = 1'b1;
    @(negedge CLK);
    spur_ps = 1'b0;
    repeat (3) @(negedge CLK);
    cmp++;
    if (PHS_CUR !== 8'd3 || BUSY !== 1'b0 || psen_cnt - p0 !== 2) begin
      mism++;
      $display("FAIL spur_psdone: got cur=%0d busy=%b psen+%0d, expected 3 0 2", PHS_CUR, BUSY, psen_cnt - p0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_down_and_same();
    test_ack_timeout();
    test_ps_timeout();
    test_reset_mid_step();
    test_lock_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
